// File: rtl/cpu_pkg.sv
// Shared pipeline types for the ARMv4 core: condition codes, flag indices
// and the decoder control word carried from D into E.
package cpu_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Storage width of the ALU operation field inside the control word.
   localparam int CTRL_ALU_W = 4;

   typedef struct packed {
      logic                  valid;
      logic                  pc_src;
      logic                  reg_write;
      logic                  mem_write;
      logic                  mem_to_reg;
      logic                  alu_src;
      logic                  branch;
      logic [1:0]            flag_w;
      logic [CTRL_ALU_W-1:0] alu_control;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator: cond field + NZCV -> pass.
module cond_check
   import cpu_pkg::*;
#(
   parameter bit NV_EXEC = 1'b0
) (
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      pass = 1'b0;
      unique case (cond_e'(cond))
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = NV_EXEC;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_ex_stage.sv
// D->E pipeline register with stall/flush, NZCV flags register and
// condition-gated commit signals for the execute stage.
module cond_ex_stage
   import cpu_pkg::*;
#(
   parameter logic [3:0] FLAGS_RST = 4'b0000,
   parameter bit         NV_EXEC   = 1'b0,
   parameter int         ALUCTL_W  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ValidD,
   input  logic [3:0]          CondD,
   input  logic                PCSrcD,
   input  logic                RegWriteD,
   input  logic                MemWriteD,
   input  logic                MemToRegD,
   input  logic                ALUSrcD,
   input  logic                BranchD,
   input  logic [1:0]          FlagWD,
   input  logic [ALUCTL_W-1:0] ALUControlD,
   input  logic                StallE,
   input  logic                FlushE,
   input  logic [3:0]          ALUFlags,
   output logic                MemToRegE,
   output logic                ALUSrcE,
   output logic [ALUCTL_W-1:0] ALUControlE,
   output logic                CondExE,
   output logic                PCSrcE,
   output logic                RegWriteE,
   output logic                MemWriteE,
   output logic                BranchTakenE,
   output logic [3:0]          Flags
);

   ctrl_t      ctrl_d;
   ctrl_t      ctrl_e_reg;
   ctrl_t      ctrl_e_next;
   logic [3:0] cond_e_reg;
   logic [3:0] cond_e_next;
   logic [3:0] flags_reg;
   logic       cond_pass;
   logic       commit;

   always_comb begin
      ctrl_d             = CTRL_BUBBLE;
      ctrl_d.valid       = ValidD;
      ctrl_d.pc_src      = PCSrcD;
      ctrl_d.reg_write   = RegWriteD;
      ctrl_d.mem_write   = MemWriteD;
      ctrl_d.mem_to_reg  = MemToRegD;
      ctrl_d.alu_src     = ALUSrcD;
      ctrl_d.branch      = BranchD;
      ctrl_d.flag_w      = FlagWD;
      ctrl_d.alu_control = CTRL_ALU_W'(ALUControlD);
   end

   // Flush outranks stall so a held instruction can still be discarded.
   always_comb begin
      ctrl_e_next = ctrl_d;
      cond_e_next = CondD;
      if (FlushE) begin
         ctrl_e_next = CTRL_BUBBLE;
         cond_e_next = 4'b0000;
      end else if (StallE) begin
         ctrl_e_next = ctrl_e_reg;
         cond_e_next = cond_e_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_e_reg <= CTRL_BUBBLE;
         cond_e_reg <= 4'b0000;
      end else begin
         ctrl_e_reg <= ctrl_e_next;
         cond_e_reg <= cond_e_next;
      end
   end

   cond_check #(
      .NV_EXEC (NV_EXEC)
   ) u_cond_check (
      .cond  (cond_e_reg),
      .flags (flags_reg),
      .pass  (cond_pass)
   );

   assign CondExE = ctrl_e_reg.valid && cond_pass;
   assign commit  = CondExE && !StallE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_reg <= FLAGS_RST;
      end else if (commit) begin
         if (ctrl_e_reg.flag_w[1]) begin
            flags_reg[FLAG_N] <= ALUFlags[FLAG_N];
            flags_reg[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (ctrl_e_reg.flag_w[0]) begin
            flags_reg[FLAG_C] <= ALUFlags[FLAG_C];
            flags_reg[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

   assign MemToRegE    = ctrl_e_reg.mem_to_reg;
   assign ALUSrcE      = ctrl_e_reg.alu_src;
   assign ALUControlE  = ALUCTL_W'(ctrl_e_reg.alu_control);
   assign PCSrcE       = ctrl_e_reg.pc_src && CondExE;
   assign RegWriteE    = ctrl_e_reg.reg_write && CondExE;
   assign MemWriteE    = ctrl_e_reg.mem_write && CondExE;
   assign BranchTakenE = ctrl_e_reg.branch && CondExE;
   assign Flags        = flags_reg;

endmodule

// File: tb/tb_cond_ex_stage.sv
// Scenario bench for cond_ex_stage; a second instance built with NV_EXEC=1
// shares all inputs so the NV encoding is covered in both variants.
module tb_cond_ex_stage;

   logic       clk;
   logic       rst_n;
   logic       ValidD;
   logic [3:0] CondD;
   logic       PCSrcD, RegWriteD, MemWriteD, MemToRegD, ALUSrcD, BranchD;
   logic [1:0] FlagWD;
   logic [3:0] ALUControlD;
   logic       StallE, FlushE;
   logic [3:0] ALUFlags;

   logic       MemToRegE, ALUSrcE, CondExE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE;
   logic [3:0] ALUControlE, Flags;
   logic       nv_MemToRegE, nv_ALUSrcE, nv_CondExE, nv_PCSrcE, nv_RegWriteE;
   logic       nv_MemWriteE, nv_BranchTakenE;
   logic [3:0] nv_ALUControlE, nv_Flags;

   // {CondExE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE}
   typedef struct {
      logic [4:0] gated;
      logic [3:0] flags;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   tests_run;
   int   tests_failed;

   cond_ex_stage #(.FLAGS_RST(4'b0000), .NV_EXEC(1'b0), .ALUCTL_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .CondD(CondD),
      .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
      .MemToRegD(MemToRegD), .ALUSrcD(ALUSrcD), .BranchD(BranchD),
      .FlagWD(FlagWD), .ALUControlD(ALUControlD), .StallE(StallE), .FlushE(FlushE),
      .ALUFlags(ALUFlags), .MemToRegE(MemToRegE), .ALUSrcE(ALUSrcE),
      .ALUControlE(ALUControlE), .CondExE(CondExE), .PCSrcE(PCSrcE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchTakenE(BranchTakenE),
      .Flags(Flags)
   );

   cond_ex_stage #(.FLAGS_RST(4'b0000), .NV_EXEC(1'b1), .ALUCTL_W(4)) dut_nv (
      .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .CondD(CondD),
      .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
      .MemToRegD(MemToRegD), .ALUSrcD(ALUSrcD), .BranchD(BranchD),
      .FlagWD(FlagWD), .ALUControlD(ALUControlD), .StallE(StallE), .FlushE(FlushE),
      .ALUFlags(ALUFlags), .MemToRegE(nv_MemToRegE), .ALUSrcE(nv_ALUSrcE),
      .ALUControlE(nv_ALUControlE), .CondExE(nv_CondExE), .PCSrcE(nv_PCSrcE),
      .RegWriteE(nv_RegWriteE), .MemWriteE(nv_MemWriteE),
      .BranchTakenE(nv_BranchTakenE), .Flags(nv_Flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] gated_now();
      return {CondExE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE};
   endfunction

   // Reference ARM condition truth table.
   function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f, input logic nv);
      logic n, z, cc, v;
      n = f[3]; z = f[2]; cc = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cc;
         4'h3: return !cc;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cc & !z;
         4'h9: return !cc | z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z & (n == v);
         4'hD: return z | (n != v);
         4'hE: return 1'b1;
         default: return nv;
      endcase
   endfunction

   task automatic drive(input logic v, input logic [3:0] c, input logic pcs, input logic rw,
                        input logic mw, input logic br, input logic [1:0] fw);
      ValidD = v; CondD = c; PCSrcD = pcs; RegWriteD = rw; MemWriteD = mw;
      BranchD = br; FlagWD = fw; MemToRegD = 1'b0; ALUSrcD = 1'b0; ALUControlD = 4'h0;
   endtask

   task automatic test_reset_initial();
      #2;
      tests_run++;
      if (Flags !== 4'b0000 || gated_now() !== 5'b0 || MemToRegE !== 1'b0 ||
          ALUSrcE !== 1'b0 || ALUControlE !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_initial: flags=%b gated=%b m2r=%b src=%b aluc=%h, need 0000/00000/0/0/0",
                  Flags, gated_now(), MemToRegE, ALUSrcE, ALUControlE);
      end else $display("[TB] reset_initial ok flags=%b", Flags);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_cmp_beq();
      @(negedge clk);
      drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
      sb.push_back('{gated: 5'b10000, flags: 4'b0000});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL cmp_issue: gated=%b flags=%b, need %b/%b", gated_now(), Flags, e.gated, e.flags);
      end else $display("[TB] cmp_issue gated=%b flags=%b", gated_now(), Flags);

      @(negedge clk);
      ALUFlags = 4'b0110;
      drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
      sb.push_back('{gated: 5'b11001, flags: 4'b0110});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL beq_taken: gated=%b flags=%b, need %b/%b", gated_now(), Flags, e.gated, e.flags);
      end else $display("[TB] beq_taken gated=%b flags=%b", gated_now(), Flags);

      @(negedge clk);
      ALUFlags = 4'b1001;
      drive(1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
      sb.push_back('{gated: 5'b00000, flags: 4'b0110});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL bne_not_taken: gated=%b flags=%b, need %b/%b", gated_now(), Flags, e.gated, e.flags);
      end else $display("[TB] bne_not_taken gated=%b flags=%b", gated_now(), Flags);
   endtask

   task automatic test_partial_flags();
      @(negedge clk);
      drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
      @(negedge clk);
      ALUFlags = 4'b1010;
      drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
      sb.push_back('{gated: 5'b10000, flags: 4'b1010});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL partial_setup: gated=%b flags=%b, need %b/%b", gated_now(), Flags, e.gated, e.flags);
      end else $display("[TB] partial_setup flags=%b", Flags);

      @(negedge clk);
      ALUFlags = 4'b0101;
      drive(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      sb.push_back('{gated: 5'b00000, flags: 4'b0110});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL partial_nz: gated=%b flags=%b, need %b/%b", gated_now(), Flags, e.gated, e.flags);
      end else $display("[TB] partial_nz flags=%b", Flags);
   endtask

   task automatic test_cond_fail();
      @(negedge clk);
      drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
      @(negedge clk);
      ALUFlags = 4'b0000;
      drive(1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11);
      sb.push_back('{gated: 5'b00000, flags: 4'b0000});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL cond_fail_gate: gated=%b flags=%b, need %b/%b", gated_now(), Flags, e.gated, e.flags);
      end else $display("[TB] cond_fail_gate gated=%b", gated_now());

      @(negedge clk);
      ALUFlags = 4'b1111;
      drive(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      sb.push_back('{gated: 5'b00000, flags: 4'b0000});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL cond_fail_flags: gated=%b flags=%b, need %b/%b", gated_now(), Flags, e.gated, e.flags);
      end else $display("[TB] cond_fail_flags flags=%b", Flags);
   endtask

   task automatic test_stall();
      @(negedge clk);
      drive(1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
      ALUControlD = 4'h5;
      @(negedge clk);
      StallE = 1'b1;
      ALUFlags = 4'b1001;
      drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{gated: 5'b10100, flags: 4'b0000});
         @(posedge clk); #1;
         e = sb.pop_front(); tests_run++;
         if (gated_now() !== e.gated || Flags !== e.flags || ALUControlE !== 4'h5) begin
            tests_failed++;
            $display("FAIL stall_hold_%0d: gated=%b flags=%b aluc=%h, need %b/%b/5",
                     i, gated_now(), Flags, ALUControlE, e.gated, e.flags);
         end else $display("[TB] stall_hold_%0d gated=%b flags=%b", i, gated_now(), Flags);
      end
      @(negedge clk);
      StallE = 1'b0;
      drive(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      sb.push_back('{gated: 5'b00000, flags: 4'b1001});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL stall_release: gated=%b flags=%b, need %b/%b", gated_now(), Flags, e.gated, e.flags);
      end else $display("[TB] stall_release flags=%b", Flags);

      @(negedge clk);
      ALUFlags = 4'b0110;
      sb.push_back('{gated: 5'b00000, flags: 4'b1001});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL stall_single_write: flags=%b, need %b", Flags, e.flags);
      end else $display("[TB] stall_single_write flags=%b", Flags);
   endtask

   task automatic test_flush_stall();
      @(negedge clk);
      drive(1'b1, 4'hE, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
      MemToRegD = 1'b1; ALUSrcD = 1'b1;
      sb.push_back('{gated: 5'b11111, flags: 4'b1001});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags || MemToRegE !== 1'b1 || ALUSrcE !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_setup: gated=%b flags=%b m2r=%b src=%b, need %b/%b/1/1",
                  gated_now(), Flags, MemToRegE, ALUSrcE, e.gated, e.flags);
      end else $display("[TB] flush_setup gated=%b", gated_now());

      @(negedge clk);
      StallE = 1'b1; FlushE = 1'b1;
      ALUFlags = 4'b0000;
      sb.push_back('{gated: 5'b00000, flags: 4'b1001});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags || MemToRegE !== 1'b0 || ALUSrcE !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_wins: gated=%b flags=%b m2r=%b src=%b, need %b/%b/0/0",
                  gated_now(), Flags, MemToRegE, ALUSrcE, e.gated, e.flags);
      end else $display("[TB] flush_wins gated=%b flags=%b", gated_now(), Flags);
      @(negedge clk);
      StallE = 1'b0; FlushE = 1'b0;
      drive(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   task automatic test_cond_sweep();
      logic exp0, exp1;
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            @(negedge clk);
            drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
            ALUFlags = 4'(f);
            @(negedge clk);
            drive(1'b1, 4'(c), 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
            exp0 = cond_ref(4'(c), 4'(f), 1'b0);
            exp1 = cond_ref(4'(c), 4'(f), 1'b1);
            sb.push_back('{gated: {exp0, 1'b0, exp1, 2'b00}, flags: 4'(f)});
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (RegWriteE !== e.gated[4] || Flags !== e.flags) begin
               tests_failed++;
               $display("FAIL sweep_nv0 cond=%h flags=%b: regwrite=%b flags=%b, need %b/%b",
                        c, f[3:0], RegWriteE, Flags, e.gated[4], e.flags);
            end
            tests_run++;
            if (nv_RegWriteE !== e.gated[2]) begin
               tests_failed++;
               $display("FAIL sweep_nv1 cond=%h flags=%b: regwrite=%b, need %b",
                        c, f[3:0], nv_RegWriteE, e.gated[2]);
            end
         end
         $display("[TB] sweep cond=%h done", c);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive(1'b1, 4'hE, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
      @(negedge clk);
      ALUFlags = 4'b1111;
      drive(1'b1, 4'hE, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
      sb.push_back('{gated: 5'b11110, flags: 4'b1111});
      @(posedge clk); #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL reset_mid_setup: gated=%b flags=%b, need %b/%b", gated_now(), Flags, e.gated, e.flags);
      end else $display("[TB] reset_mid_setup flags=%b", Flags);
      #2;
      rst_n = 1'b0;
      sb.push_back('{gated: 5'b00000, flags: 4'b0000});
      #1;
      e = sb.pop_front(); tests_run++;
      if (gated_now() !== e.gated || Flags !== e.flags) begin
         tests_failed++;
         $display("FAIL reset_async: gated=%b flags=%b, need %b/%b", gated_now(), Flags, e.gated, e.flags);
      end else $display("[TB] reset_async flags=%b gated=%b", Flags, gated_now());
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0; ALUFlags = 4'b0000;
      drive(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      test_reset_initial();
      test_cmp_beq();
      test_partial_flags();
      test_cond_fail();
      test_stall();
      test_flush_stall();
      test_cond_sweep();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time %0t exceeded budget", $time);
      $fatal(1);
   end

endmodule

// File: doc/cond_ex_stage.md
Name: cond_ex_stage

Overview:
- Decode-to-execute boundary stage of the ARMv4 pipeline, directly downstream of the control decoder.
- Registers the decoder's control word into the E stage and supports stall and flush.
- Holds the architectural NZCV flags register, evaluates the instruction's 4-bit condition field against it, and produces gated PCSrc/RegWrite/MemWrite for execute, memory and fetch.
- Updates flags from the ALU when the executing instruction passes its condition and requests a flag write.

Parameters:
- FLAGS_RST, 4'b0000, reset value of NZCV register.
- NV_EXEC, 0, if 1 then Cond=4'b1111 executes as AL; if 0 it never executes.
- ALUCTL_W, 4, width of ALUControl field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ValidD  in  1  decode slot holds a real instruction.
- CondD  in  4  instruction condition field.
- PCSrcD, RegWriteD, MemWriteD, MemToRegD, ALUSrcD, BranchD  in  1 each  decoder control bits.
- FlagWD  in  2  [1]=update N,Z; [0]=update C,V.
- ALUControlD  in  ALUCTL_W  decoder ALU operation.
- StallE  in  1  hold E register, suppress commit.
- FlushE  in  1  load bubble into E.
- ALUFlags  in  4  {N,Z,C,V} from execute ALU, current cycle.
- MemToRegE, ALUSrcE  out  1 each  registered, ungated.
- ALUControlE  out  ALUCTL_W  registered.
- CondExE  out  1  E instruction valid and condition passed.
- PCSrcE, RegWriteE, MemWriteE  out  1 each  registered bit AND CondExE.
- BranchTakenE  out  1  BranchE AND CondExE.
- Flags  out  4  current NZCV register.

Behaviour:
- Reset (rst_n=0, async): E register cleared (ValidE=0, all control bits 0, ALUControlE=0). Flags=FLAGS_RST. Consequently all gated outputs and CondExE are 0. Release is synchronous to the next clk edge.
- E register update each rising edge, in priority order:
  - FlushE=1: bubble (all fields 0, ValidE=0). FlushE wins over StallE.
  - else StallE=1: hold.
  - else capture all D inputs.
- Latency: one cycle from D inputs to E outputs.
- Condition evaluation is combinational in E, using the Flags register (not ALUFlags). With N=Flags[3], Z=[2], C=[1], V=[0]:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: NV_EXEC
- CondExE = ValidE AND condition.
- Flag write on rising edge when CondExE=1 and StallE=0:
  - FlagWE[1] loads N,Z from ALUFlags[3:2].
  - FlagWE[0] loads C,V from ALUFlags[1:0].
  - Unselected bits hold.
- Flags are visible to the next E instruction with no forwarding. Back-to-back CMP followed by a conditional instruction is correct by construction.
- A flushed or condition-failed instruction never writes flags, registers or memory, and never redirects PC.
- Stall with a pending flag write: no write while stalled. Exactly one write occurs on the cycle StallE drops, provided the condition still passes.
- FlushE and StallE together: flush wins; the held instruction is discarded and performs no commit in that cycle.
- Reset asserted mid-operation: immediate clear of E and Flags; no partial commit.

Decomposition:
- Shared package cpu_pkg:
  - cond_e enum (EQ..AL, NV, 4-bit).
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - ctrl_t packed struct of the decoder control word (Valid, PCSrc, RegWrite, MemWrite, MemToReg, ALUSrc, Branch, FlagW, ALUControl).
  - CTRL_BUBBLE constant.
- One sub-module, cond_check: pure combinational Cond+Flags -> pass. Reused by any future predication logic.

Test Plan:
- Reset: rst_n=0 mid-stream with Flags=4'b1111 -> Flags=4'b0000, RegWriteE=MemWriteE=PCSrcE=CondExE=0 immediately, before any clk edge.
- CMP then BEQ:
  - Cycle 1: FlagWD=2'b11, ALUFlags=4'b0110, CondD=AL.
  - Next cycle: Flags=4'b0110.
  - Branch with CondD=0000, BranchD=1 -> BranchTakenE=1, PCSrcE=1.
  - Same branch with CondD=0001 -> both 0.
- Partial flag write: Flags=4'b1010, FlagWD=2'b10, ALUFlags=4'b0101 -> Flags=4'b0110 (C,V preserved).
- Condition fail blocks commit: Flags=4'b0000, CondD=0000, RegWriteD=1, MemWriteD=1, FlagWD=2'b11 -> RegWriteE=MemWriteE=0, Flags unchanged.
- Stall/flush:
  - StallE=1 for 3 cycles with AL, FlagWD=2'b11 -> E outputs held, Flags unchanged until StallE=0, then a single update.
  - FlushE=1 together with StallE=1 -> ValidE=0, all gated outputs 0 next cycle.
- Full condition sweep: all 16 Cond × 16 Flags values with RegWriteD=1 -> RegWriteE matches the truth table.
  - Cond=1111 gives 0 with NV_EXEC=0.
  - Cond=1111 gives 1 in a second build with NV_EXEC=1.
